// File: rtl/fifo_pkg.sv
// fifo_pkg: shared sizing constants and the control FSM state encoding for fifo_8x32.
//   DATA_WIDTH : width of each stored word and of din/dout
//   DEPTH      : number of entries (power of two)
//   ADDR_WIDTH : width of the head/tail pointers, log2(DEPTH)
//   CNT_WIDTH  : width of data_count, wide enough to hold DEPTH itself
package fifo_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned DEPTH      = 8;
  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);
  localparam int unsigned CNT_WIDTH  = ADDR_WIDTH + 1;

  // Encodings are fixed so that the state register can be probed directly.
  typedef enum logic [2:0] {
    StInit    = 3'b000,
    StNoOp    = 3'b001,
    StWrite   = 3'b010,
    StWrError = 3'b011,
    StRead    = 3'b100,
    StRdError = 3'b101
  } state_e;

endpackage

// File: rtl/register32_en.sv
// register32_en: one enable-gated storage word of the FIFO array.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset, clears the word
//   en      : load enable, d is captured on the rising edge while high
//   d       : data in
//   q       : stored word
module register32_en
  import fifo_pkg::*;
#(
  parameter int unsigned Width = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Width-1:0] q_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q <= '0;
    end else if (en) begin
      q_q <= d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/fifo_8x32.sv
// fifo_8x32: 8-entry, 32-bit synchronous FIFO with a six-state control FSM.
//   clk        : rising-edge clock, single domain
//   reset_n    : asynchronous active-low reset; clears pointers, count, dout and status
//   wr_en      : write request
//   rd_en      : read request (both high together is ignored)
//   din        : write data
//   dout       : registered read data, updated on the edge that enters READ
//   data_count : current occupancy, 0..DEPTH
//   full       : data_count == DEPTH
//   empty      : data_count == 0
//   wr_ack     : high while in WRITE (write accepted)
//   wr_err     : high while in WR_ERROR (write while full, dropped)
//   rd_ack     : high while in READ (dout holds the word just read)
//   rd_err     : high while in RD_ERROR (read while empty, dropped)
module fifo_8x32
  import fifo_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [CNT_WIDTH-1:0]  data_count,
  output logic                  full,
  output logic                  empty,
  output logic                  wr_ack,
  output logic                  wr_err,
  output logic                  rd_ack,
  output logic                  rd_err
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] head_q, head_d;
  logic [ADDR_WIDTH-1:0] tail_q, tail_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]      wr_sel;
  logic                  is_full, is_empty;

  // Occupancy alone separates full from empty: head == tail in both cases.
  assign is_full  = (count_q == CNT_WIDTH'(DEPTH));
  assign is_empty = (count_q == '0);

  // ---------------------------------------------------------------------------
  // Control FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StInit;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM: next state. The decision depends only on the current request
  // and occupancy, so every state (INIT included) shares the same decode.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = StNoOp;
    case ({wr_en, rd_en})
      2'b10:   state_d = is_full  ? StWrError : StWrite;
      2'b01:   state_d = is_empty ? StRdError : StRead;
      default: state_d = StNoOp;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control FSM: status outputs, decoded from the registered state so each
  // flag is high exactly for the cycle spent in its state.
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ack = 1'b0;
    wr_err = 1'b0;
    rd_ack = 1'b0;
    rd_err = 1'b0;
    case (state_q)
      StWrite:   wr_ack = 1'b1;
      StWrError: wr_err = 1'b1;
      StRead:    rd_ack = 1'b1;
      StRdError: rd_err = 1'b1;
      default:   ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pointer, count and read-data next state. Data actions are keyed off the
  // state being entered so they land on the same edge as the state change.
  // ---------------------------------------------------------------------------
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    dout_d  = dout_q;
    case (state_d)
      StWrite: begin
        tail_d  = tail_q + 1'b1;  // wraps DEPTH-1 -> 0
        count_d = count_q + 1'b1;
      end
      StRead: begin
        dout_d  = mem_q[head_q];
        head_d  = head_q + 1'b1;  // wraps DEPTH-1 -> 0
        count_d = count_q - 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      dout_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      dout_q  <= dout_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage array: one enable-gated word per entry, loaded when entering WRITE
  // and the tail points at it.
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < DEPTH; i++) begin : g_mem
    assign wr_sel[i] = (state_d == StWrite) && (tail_q == ADDR_WIDTH'(i));

    register32_en #(
      .Width (DATA_WIDTH)
    ) u_word (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (wr_sel[i]),
      .d       (din),
      .q       (mem_q[i])
    );
  end

  assign dout       = dout_q;
  assign data_count = count_q;
  assign full       = is_full;
  assign empty      = is_empty;

  // Occupancy never leaves 0..DEPTH regardless of the request pattern.
  a_count_bound: assert property (@(posedge clk) disable iff (!reset_n)
    count_q <= CNT_WIDTH'(DEPTH));

  // Status flags are mutually exclusive.
  a_status_onehot: assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0({wr_ack, wr_err, rd_ack, rd_err}));

endmodule

// File: tb/tb_fifo_8x32.sv
// tb_fifo_8x32: directed, table-driven bench for fifo_8x32 with hand-written
// sequences for asynchronous reset.
module tb_fifo_8x32;

  logic        clk;
  logic        reset_n;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] din;
  logic [31:0] dout;
  logic [3:0]  data_count;
  logic        full;
  logic        empty;
  logic        wr_ack;
  logic        wr_err;
  logic        rd_ack;
  logic        rd_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] din;
    logic [31:0] dout;
    logic [3:0]  cnt;
    logic        full;
    logic        empty;
    logic        wack;
    logic        werr;
    logic        rack;
    logic        rerr;
  } vec_t;

  vec_t vecs[$];

  fifo_8x32 dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .din        (din),
    .dout       (dout),
    .data_count (data_count),
    .full       (full),
    .empty      (empty),
    .wr_ack     (wr_ack),
    .wr_err     (wr_err),
    .rd_ack     (rd_ack),
    .rd_err     (rd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input vec_t v);
    chk({tag, " dout"},   dout,       v.dout);
    chk({tag, " count"},  32'(data_count), 32'(v.cnt));
    chk({tag, " full"},   32'(full),   32'(v.full));
    chk({tag, " empty"},  32'(empty),  32'(v.empty));
    chk({tag, " wr_ack"}, 32'(wr_ack), 32'(v.wack));
    chk({tag, " wr_err"}, 32'(wr_err), 32'(v.werr));
    chk({tag, " rd_ack"}, 32'(rd_ack), 32'(v.rack));
    chk({tag, " rd_err"}, 32'(rd_err), 32'(v.rerr));
  endtask

  function automatic void add(input logic wr, input logic rd, input logic [31:0] d,
                              input logic [31:0] q, input int cnt, input logic wack,
                              input logic werr, input logic rack, input logic rerr);
    vec_t v;
    v.wr = wr; v.rd = rd; v.din = d; v.dout = q; v.cnt = 4'(cnt);
    v.full = (cnt == 8); v.empty = (cnt == 0);
    v.wack = wack; v.werr = werr; v.rack = rack; v.rerr = rerr;
    vecs.push_back(v);
  endfunction

  task automatic step(input logic wr, input logic rd, input logic [31:0] d);
    wr_en = wr;
    rd_en = rd;
    din   = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t rst_v;

    // Idle after reset.
    for (int i = 0; i < 3; i++) add(0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 0);
    // Fill with 1..8, then an overflow attempt.
    for (int i = 1; i <= 8; i++) add(1, 0, 32'(i), 32'h0, i, 1, 0, 0, 0);
    add(1, 0, 32'hDEADBEEF, 32'h0, 8, 0, 1, 0, 0);
    // Drain in order, then an underflow attempt; dout keeps the last word.
    for (int i = 1; i <= 8; i++) add(0, 1, 32'h0, 32'(i), 8 - i, 0, 0, 1, 0);
    add(0, 1, 32'h0, 32'h8, 0, 0, 0, 0, 1);
    // Wrap: pointers now at 0; 5 in/out moves them to 5, then 6 in/out crosses 7->0.
    for (int i = 0; i < 5; i++) add(1, 0, 32'h10 + 32'(i), 32'h8, i + 1, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 1, 32'h0, 32'h10 + 32'(i), 4 - i, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) add(1, 0, 32'hA0 + 32'(i), 32'h14, i + 1, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) add(0, 1, 32'h0, 32'hA0 + 32'(i), 5 - i, 0, 0, 1, 0);
    // Three words in, then simultaneous requests are ignored for two cycles.
    for (int i = 0; i < 3; i++) add(1, 0, 32'hB0 + 32'(i), 32'hA5, i + 1, 1, 0, 0, 0);
    add(1, 1, 32'hFFFF_FFFF, 32'hA5, 3, 0, 0, 0, 0);
    add(1, 1, 32'hFFFF_FFFF, 32'hA5, 3, 0, 0, 0, 0);
    // A fourth word so the reset below discards a partly filled FIFO.
    add(1, 0, 32'hB3, 32'hA5, 4, 1, 0, 0, 0);

    reset_n = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    din     = 32'h0;

    rst_v.dout = 32'h0; rst_v.cnt = 4'd0; rst_v.full = 1'b0; rst_v.empty = 1'b1;
    rst_v.wack = 1'b0; rst_v.werr = 1'b0; rst_v.rack = 1'b0; rst_v.rerr = 1'b0;
    rst_v.wr = 1'b0; rst_v.rd = 1'b0; rst_v.din = 32'h0;

    #7;
    check_all("in_reset", rst_v);
    #5 reset_n = 1'b1;  // released between edges

    foreach (vecs[i]) begin
      step(vecs[i].wr, vecs[i].rd, vecs[i].din);
      check_all($sformatf("vec%0d", i), vecs[i]);
    end

    // Asynchronous reset mid-cycle: everything clears before the next edge.
    wr_en = 1'b0;
    rd_en = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check_all("async_reset", rst_v);
    @(negedge clk);
    reset_n = 1'b1;

    // Contents were discarded, so the first read is rejected.
    step(0, 1, 32'h0);
    rst_v.rerr = 1'b1;
    check_all("read_after_reset", rst_v);

    // A write after reset lands at entry 0 and reads back.
    step(1, 0, 32'h1234_5678);
    chk("post_reset write ack", 32'(wr_ack), 32'h1);
    step(0, 1, 32'h0);
    chk("post_reset read data", dout, 32'h1234_5678);
    chk("post_reset read ack", 32'(rd_ack), 32'h1);
    chk("post_reset empty", 32'(empty), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
